// File: rtl/riscv_v_rf_fwd_pipe.sv
// Vector RF write staging (ID..WB) with byte-granular forwarding into registered read sources.
// Optional feature macro: RISCV_V_RF_FWD_EN (forwarding muxes; otherwise stall on any in-flight match).
module riscv_v_rf_fwd_pipe #(
  parameter int unsigned DATA_WIDTH       = 128,
  parameter int unsigned ADDR_WIDTH       = 5,
  parameter int unsigned NUM_SRC          = 3,
  parameter int unsigned EXE_2_WB_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            stall,
  input  logic                            flush,
  input  logic [ADDR_WIDTH-1:0]           rf_wr_addr_id,
  input  logic                            rf_wr_late_id,
  input  logic [DATA_WIDTH/8-1:0]         rf_wr_en_exe,
  input  logic [DATA_WIDTH-1:0]           rf_wr_data_exe,
  input  logic [DATA_WIDTH-1:0]           rf_wr_late_data_mem,
  output logic [ADDR_WIDTH-1:0]           rf_wr_addr_exe,
  output logic [ADDR_WIDTH-1:0]           rf_wr_addr_mem,
  output logic [ADDR_WIDTH-1:0]           rf_wr_addr_wb,
  output logic [DATA_WIDTH/8-1:0]         rf_wr_en_mem,
  output logic [DATA_WIDTH/8-1:0]         rf_wr_en_wb,
  output logic [DATA_WIDTH-1:0]           rf_wr_data_mem,
  output logic [DATA_WIDTH-1:0]           rf_wr_data_wb,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]   rf_rd_addr_id,
  input  logic [NUM_SRC-1:0]              rf_rd_vld_id,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   rf_rd_data_id,
  output logic [NUM_SRC*DATA_WIDTH-1:0]   rf_rd_data_exe,
  output logic                            hazard_stall
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned D  = EXE_2_WB_LATENCY;

  logic [ADDR_WIDTH-1:0]         addr_exe_q;
  logic                          late_exe_q;
  logic                          late_mem_q;
  logic [ADDR_WIDTH-1:0]         addr_q [1:D];
  logic [NB-1:0]                 en_q   [1:D];
  logic [DATA_WIDTH-1:0]         data_q [1:D];
  logic [DATA_WIDTH-1:0]         wr_data_stg [1:D];
  logic [NUM_SRC*DATA_WIDTH-1:0] rd_data_q;
  logic [NUM_SRC*DATA_WIDTH-1:0] rd_data_d;
  logic                          hazard;

  // Stage-1 data already reflects the late (load) result; later stages capture the substituted value.
  always_comb begin
    for (int unsigned s = 1; s <= D; s++) begin
      wr_data_stg[s] = data_q[s];
    end
    if (late_mem_q) begin
      wr_data_stg[1] = rf_wr_late_data_mem;
    end
  end

`ifdef RISCV_V_RF_FWD_EN
  // Walk oldest stage first so younger writes overwrite older ones per byte; EXE wins last.
  always_comb begin
    rd_data_d = rf_rd_data_id;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned b = 0; b < NB; b++) begin
        for (int unsigned k = 0; k < D; k++) begin
          if (addr_q[D-k] == rf_rd_addr_id[i*ADDR_WIDTH +: ADDR_WIDTH] && en_q[D-k][b]) begin
            rd_data_d[i*DATA_WIDTH + b*8 +: 8] = wr_data_stg[D-k][b*8 +: 8];
          end
        end
        if (addr_exe_q == rf_rd_addr_id[i*ADDR_WIDTH +: ADDR_WIDTH] && rf_wr_en_exe[b] && !late_exe_q) begin
          rd_data_d[i*DATA_WIDTH + b*8 +: 8] = rf_wr_data_exe[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (rf_rd_vld_id[i] && late_exe_q && (|rf_wr_en_exe) &&
          rf_rd_addr_id[i*ADDR_WIDTH +: ADDR_WIDTH] == addr_exe_q) begin
        hazard = 1'b1;
      end
    end
  end
`else
  assign rd_data_d = rf_rd_data_id;

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (rf_rd_vld_id[i]) begin
        if ((|rf_wr_en_exe) && rf_rd_addr_id[i*ADDR_WIDTH +: ADDR_WIDTH] == addr_exe_q) begin
          hazard = 1'b1;
        end
        for (int unsigned s = 1; s <= D; s++) begin
          if ((|en_q[s]) && rf_rd_addr_id[i*ADDR_WIDTH +: ADDR_WIDTH] == addr_q[s]) begin
            hazard = 1'b1;
          end
        end
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_exe_q <= '0;
      late_exe_q <= 1'b0;
      late_mem_q <= 1'b0;
      rd_data_q  <= '0;
      for (int unsigned s = 1; s <= D; s++) begin
        addr_q[s] <= '0;
        en_q[s]   <= '0;
        data_q[s] <= '0;
      end
    end else begin
      if (!stall) begin
        addr_exe_q <= rf_wr_addr_id;
        addr_q[1]  <= addr_exe_q;
        data_q[1]  <= rf_wr_data_exe;
        late_mem_q <= late_exe_q;
        rd_data_q  <= rd_data_d;
        for (int unsigned s = 2; s <= D; s++) begin
          addr_q[s] <= addr_q[s-1];
          data_q[s] <= wr_data_stg[s-1];
        end
      end
      // Flush squashes enables even while stalled; everything else follows stall.
      if (flush) begin
        late_exe_q <= 1'b0;
        for (int unsigned s = 1; s <= D; s++) begin
          en_q[s] <= '0;
        end
      end else if (!stall) begin
        late_exe_q <= rf_wr_late_id;
        en_q[1]    <= rf_wr_en_exe;
        for (int unsigned s = 2; s <= D; s++) begin
          en_q[s] <= en_q[s-1];
        end
      end
    end
  end

  assign rf_wr_addr_exe = addr_exe_q;
  assign rf_wr_addr_mem = addr_q[1];
  assign rf_wr_addr_wb  = addr_q[D];
  assign rf_wr_en_mem   = en_q[1];
  assign rf_wr_en_wb    = en_q[D];
  assign rf_wr_data_mem = wr_data_stg[1];
  assign rf_wr_data_wb  = wr_data_stg[D];
  assign rf_rd_data_exe = rd_data_q;
  assign hazard_stall   = rst & hazard;

endmodule

// File: tb/tb_riscv_v_rf_fwd_pipe.sv
// Directed bench for riscv_v_rf_fwd_pipe; expectations depend on RISCV_V_RF_FWD_EN.
module tb_riscv_v_rf_fwd_pipe;

  localparam int DW = 128;
  localparam int AW = 5;
  localparam int NS = 3;
  localparam int D  = 2;
  localparam int NB = DW / 8;
`ifdef RISCV_V_RF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int S_AEXE = 0, S_AMEM = 1, S_EMEM = 2, S_DMEM = 3;
  localparam int S_AWB = 4, S_EWB = 5, S_DWB = 6, S_RD0 = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, stall, flush, rf_wr_late_id, hazard_stall;
  logic [AW-1:0]    rf_wr_addr_id, rf_wr_addr_exe, rf_wr_addr_mem, rf_wr_addr_wb;
  logic [NB-1:0]    rf_wr_en_exe, rf_wr_en_mem, rf_wr_en_wb;
  logic [DW-1:0]    rf_wr_data_exe, rf_wr_late_data_mem, rf_wr_data_mem, rf_wr_data_wb;
  logic [NS*AW-1:0] rf_rd_addr_id;
  logic [NS-1:0]    rf_rd_vld_id;
  logic [NS*DW-1:0] rf_rd_data_id, rf_rd_data_exe;

  riscv_v_rf_fwd_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SRC(NS), .EXE_2_WB_LATENCY(D)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .rf_wr_addr_id(rf_wr_addr_id), .rf_wr_late_id(rf_wr_late_id),
    .rf_wr_en_exe(rf_wr_en_exe), .rf_wr_data_exe(rf_wr_data_exe),
    .rf_wr_late_data_mem(rf_wr_late_data_mem),
    .rf_wr_addr_exe(rf_wr_addr_exe), .rf_wr_addr_mem(rf_wr_addr_mem), .rf_wr_addr_wb(rf_wr_addr_wb),
    .rf_wr_en_mem(rf_wr_en_mem), .rf_wr_en_wb(rf_wr_en_wb),
    .rf_wr_data_mem(rf_wr_data_mem), .rf_wr_data_wb(rf_wr_data_wb),
    .rf_rd_addr_id(rf_rd_addr_id), .rf_rd_vld_id(rf_rd_vld_id),
    .rf_rd_data_id(rf_rd_data_id), .rf_rd_data_exe(rf_rd_data_exe),
    .hazard_stall(hazard_stall)
  );

  typedef struct {
    int            due;
    int            sel;
    string         tag;
    logic [DW-1:0] exp;
  } item_t;

  item_t sbq[$];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] DA, DB, DC, DX, DJ, DL, DS, DQ, R0, R1, R2, merged;

  function automatic logic [DW-1:0] obs(int sel);
    case (sel)
      S_AEXE:  return DW'(rf_wr_addr_exe);
      S_AMEM:  return DW'(rf_wr_addr_mem);
      S_EMEM:  return DW'(rf_wr_en_mem);
      S_DMEM:  return rf_wr_data_mem;
      S_AWB:   return DW'(rf_wr_addr_wb);
      S_EWB:   return DW'(rf_wr_en_wb);
      S_DWB:   return rf_wr_data_wb;
      default: return rf_rd_data_exe[(sel-S_RD0)*DW +: DW];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic expect_out(input int lat, input int sel, input string tag, input logic [DW-1:0] e);
    item_t it;
    it.due = cyc + lat;
    it.sel = sel;
    it.tag = tag;
    it.exp = e;
    sbq.push_back(it);
  endtask

  task automatic tick();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    k = 0;
    while (k < sbq.size()) begin
      if (sbq[k].due <= cyc) begin
        chk(sbq[k].tag, obs(sbq[k].sel), sbq[k].exp);
        sbq.delete(k);
      end else begin
        k++;
      end
    end
  endtask

  function automatic logic [DW-1:0] rand_dw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_inputs();
    rf_wr_addr_id       = AW'($urandom);
    rf_wr_late_id       = 1'($urandom);
    rf_wr_en_exe        = NB'($urandom);
    rf_wr_data_exe      = rand_dw();
    rf_wr_late_data_mem = rand_dw();
    rf_rd_addr_id       = (NS*AW)'($urandom);
    rf_rd_vld_id        = NS'($urandom);
    for (int i = 0; i < NS; i++) rf_rd_data_id[i*DW +: DW] = rand_dw();
  endtask

  task automatic idle();
    stall = 1'b0; flush = 1'b0;
    rf_wr_addr_id = '0; rf_wr_late_id = 1'b0; rf_wr_en_exe = '0;
    rf_wr_data_exe = '0; rf_wr_late_data_mem = '0;
    rf_rd_addr_id = '0; rf_rd_vld_id = '0; rf_rd_data_id = '0;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic src(input int i, input int addr, input bit vld, input logic [DW-1:0] data);
    rf_rd_addr_id[i*AW +: AW] = AW'(addr);
    rf_rd_vld_id[i]           = vld;
    rf_rd_data_id[i*DW +: DW] = data;
  endtask

  initial begin
    DA = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    DB = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    DC = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
    DX = 128'hDEAD0000_DEAD1111_DEAD2222_DEAD3333;
    DJ = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    DL = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    DS = 128'h5555_AAAA_5555_AAAA_0F0F_F0F0_3C3C_C3C3;
    DQ = 128'h9999_8888_7777_6666_5555_4444_3333_2222;
    R0 = 128'h0000_1111_0000_1111_0000_1111_0000_1111;
    R1 = 128'h2222_3333_2222_3333_2222_3333_2222_3333;
    R2 = 128'h4444_5555_4444_5555_4444_5555_4444_5555;
    merged = {DB[127:64], DA[63:0]};

    // Reset with random inputs
    rst = 1'b0;
    idle();
    repeat (3) begin
      rand_inputs();
      stall = 1'($urandom);
      flush = 1'($urandom);
      tick();
    end
    for (int s = 0; s <= S_DWB; s++) chk($sformatf("reset_out%0d", s), obs(s), '0);
    for (int i = 0; i < NS; i++) chk($sformatf("reset_rd%0d", i), obs(S_RD0 + i), '0);
    chk("reset_hazard", DW'(hazard_stall), '0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic write to v7 through to WB
    rf_wr_addr_id = 5'd7;
    tick();
    chk("addr_exe_v7", DW'(rf_wr_addr_exe), DW'(7));
    rf_wr_addr_id  = '0;
    rf_wr_en_exe   = 16'hFFFF;
    rf_wr_data_exe = DA;
    expect_out(1, S_EMEM, "en_mem_v7", DW'(16'hFFFF));
    expect_out(1, S_AMEM, "addr_mem_v7", DW'(7));
    expect_out(2, S_AWB, "addr_wb_v7", DW'(7));
    expect_out(2, S_EWB, "en_wb_v7", DW'(16'hFFFF));
    expect_out(2, S_DWB, "data_wb_v7", DA);
    tick();
    drain();

    // Byte merge: WB holds low half, MEM holds high half of v3
    rf_wr_addr_id = 5'd3;
    tick();
    rf_wr_en_exe = 16'h00FF; rf_wr_data_exe = DA; rf_wr_addr_id = 5'd3;
    tick();
    rf_wr_en_exe = 16'hFF00; rf_wr_data_exe = DB; rf_wr_addr_id = '0;
    tick();
    rf_wr_en_exe = '0; rf_wr_data_exe = '0;
    src(0, 3, 1'b1, R0);
    src(1, 4, 1'b1, R1);
    src(2, 3, 1'b0, R2);
    #1;
    chk("merge_hazard", DW'(hazard_stall), DW'(!FWD));
    chk("merge_en_wb", DW'(rf_wr_en_wb), DW'(16'h00FF));
    chk("merge_data_mem", rf_wr_data_mem, DB);
    expect_out(1, S_RD0 + 0, "merge_src0", FWD ? merged : R0);
    expect_out(1, S_RD0 + 1, "merge_src1_nomatch", R1);
    expect_out(1, S_RD0 + 2, "merge_src2_unused", FWD ? merged : R2);
    tick();
    drain();

    // Priority: EXE beats MEM; late EXE is skipped and raises hazard
    rf_wr_addr_id = 5'd3;
    tick();
    rf_wr_en_exe = 16'hFFFF; rf_wr_data_exe = DB; rf_wr_addr_id = 5'd3;
    tick();
    rf_wr_en_exe = 16'hFFFF; rf_wr_data_exe = DC; rf_wr_addr_id = '0;
    src(0, 3, 1'b1, R0);
    #1;
    chk("prio_hazard", DW'(hazard_stall), DW'(!FWD));
    expect_out(1, S_RD0 + 0, "prio_exe_over_mem", FWD ? DC : R0);
    tick();
    rf_wr_addr_id = 5'd3; rf_wr_late_id = 1'b1; rf_wr_en_exe = '0; rf_wr_data_exe = '0;
    src(0, 0, 1'b0, '0);
    tick();
    rf_wr_addr_id = '0; rf_wr_late_id = 1'b0;
    rf_wr_en_exe = 16'hFFFF; rf_wr_data_exe = DX;
    src(0, 3, 1'b1, R0);
    #1;
    chk("late_exe_hazard", DW'(hazard_stall), DW'(1));
    expect_out(1, S_RD0 + 0, "late_exe_skipped", FWD ? DC : R0);
    tick();
    drain();

    // Late load to v5, consumer held in ID for one bubble
    rf_wr_addr_id = 5'd5; rf_wr_late_id = 1'b1;
    tick();
    rf_wr_late_id = 1'b0; rf_wr_addr_id = 5'd9;
    rf_wr_en_exe = 16'hFFFF; rf_wr_data_exe = DJ;
    src(1, 5, 1'b1, R1);
    #1;
    chk("load_use_hazard", DW'(hazard_stall), DW'(1));
    tick();
    rf_wr_en_exe = '0; rf_wr_data_exe = '0; rf_wr_late_data_mem = DL;
    #1;
    chk("load_bubble_hazard", DW'(hazard_stall), DW'(!FWD));
    chk("late_data_mem", rf_wr_data_mem, DL);
    expect_out(1, S_RD0 + 1, "late_fwd_mem", FWD ? DL : R1);
    expect_out(1, S_DWB, "late_data_wb", DL);
    expect_out(1, S_EWB, "late_en_wb", DW'(16'hFFFF));
    tick();
    drain();

    // Stall holds everything; flush under stall clears only enables
    rf_wr_addr_id = 5'd6;
    tick();
    rf_wr_addr_id = '0; rf_wr_en_exe = 16'hFFFF; rf_wr_data_exe = DS;
    src(0, 1, 1'b0, DQ);
    tick();
    repeat (2) begin
      rand_inputs();
      stall = 1'b1;
      expect_out(1, S_AEXE, "stall_addr_exe", DW'(0));
      expect_out(1, S_AMEM, "stall_addr_mem", DW'(6));
      expect_out(1, S_EMEM, "stall_en_mem", DW'(16'hFFFF));
      expect_out(1, S_DMEM, "stall_data_mem", DS);
      expect_out(1, S_EWB, "stall_en_wb", DW'(0));
      expect_out(1, S_RD0 + 0, "stall_rd0", DQ);
      tick();
    end
    flush = 1'b1;
    expect_out(1, S_EMEM, "flush_en_mem", DW'(0));
    expect_out(1, S_EWB, "flush_en_wb", DW'(0));
    expect_out(1, S_AMEM, "flush_addr_mem", DW'(6));
    expect_out(1, S_DMEM, "flush_data_mem", DS);
    expect_out(1, S_RD0 + 0, "flush_rd0", DQ);
    tick();
    drain();

    // Reset mid-stream drops the in-flight write
    rf_wr_addr_id = 5'd2;
    tick();
    rf_wr_addr_id = '0; rf_wr_en_exe = 16'hFFFF; rf_wr_data_exe = DS;
    tick();
    rf_wr_en_exe = '0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_en_mem", DW'(rf_wr_en_mem), '0);
    chk("async_rst_addr_mem", DW'(rf_wr_addr_mem), '0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_en_wb_a", DW'(rf_wr_en_wb), '0);
    tick();
    chk("post_rst_en_wb_b", DW'(rf_wr_en_wb), '0);

    chk("scoreboard_empty", DW'(sbq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_v_rf_fwd_pipe.md
# riscv_v_rf_fwd_pipe

Parametrised vector register-file pipeline controller, successor to the fixed-width RF staging control. It stages the vector RF write address, byte enables and data from ID through WB, and registers per-source RF read data from ID into EXE. On the way it forwards in-flight write data at byte granularity into each read source. It also raises a hazard request when a source depends on a result that is not available until MEM.

## Interface
Parameters:
- DATA_WIDTH, 128, vector data width in bits; multiple of 8. NB = DATA_WIDTH/8.
- ADDR_WIDTH, 5, RF address width.
- NUM_SRC, 3, number of read sources (srca/srcb/srcc).
- EXE_2_WB_LATENCY, 2, write-pipeline depth D, at least 1. Stage 1 is MEM, stage D is WB.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold every pipeline register.
- flush  in  1  synchronous squash of write enables.
- rf_wr_addr_id  in  ADDR_WIDTH  destination of the instruction in ID.
- rf_wr_late_id  in  1  set when the instruction's result is only valid at MEM (load).
- rf_wr_en_exe  in  NB  byte write enables produced in EXE.
- rf_wr_data_exe  in  DATA_WIDTH  EXE result.
- rf_wr_late_data_mem  in  DATA_WIDTH  late result, valid in MEM.
- rf_wr_addr_exe / rf_wr_addr_mem / rf_wr_addr_wb  out  ADDR_WIDTH  staged destination.
- rf_wr_en_mem / rf_wr_en_wb  out  NB  staged byte enables.
- rf_wr_data_mem / rf_wr_data_wb  out  DATA_WIDTH  staged data; rf_wr_data_mem already carries the late-data substitution.
- rf_rd_addr_id  in  NUM_SRC*ADDR_WIDTH  source addresses; source i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- rf_rd_vld_id  in  NUM_SRC  source i is used.
- rf_rd_data_id  in  NUM_SRC*DATA_WIDTH  raw RF read data.
- rf_rd_data_exe  out  NUM_SRC*DATA_WIDTH  forwarded, registered source data.
- hazard_stall  out  1  combinational load-use request to the hazard unit.

## Operation
- **Address staging.** rf_wr_addr_id and rf_wr_late_id are registered into EXE. EXE entries then propagate through D further stages.
- **Enable and data staging.** rf_wr_en_exe and rf_wr_data_exe propagate through D stages.
- **Late-data substitution.** On entry to MEM, when the EXE late flag is set, the MEM data register loads rf_wr_late_data_mem one cycle later instead of the EXE data. Equivalently, the stage-1 data output is muxed by the stage-1 late flag.
- **Forwarding (byte-wise).** For each source i and each byte b, the first match in this priority order wins:
  1. EXE: address equal, rf_wr_en_exe[b] set, late flag clear.
  2. Stages 1..D, youngest first: address equal and staged en[b] set.
  3. Otherwise rf_rd_data_id.
- **Result registration.** The selected data is registered into rf_rd_data_exe.
- **Hazard.** hazard_stall = OR over i of: rf_rd_vld_id[i], address equal to rf_wr_addr_exe, EXE late flag set, and rf_wr_en_exe nonzero.
- **Stall.** When stall is asserted, all registers hold, including rf_rd_data_exe.
- **Flush.** flush clears the EXE late flag and every staged wr_en register. Flush has priority over stall. Address and data registers are unchanged.
- **Unused sources.** A source with rf_rd_vld_id clear still registers data; forwarding applies normally.

## Timing
- **Reset.** While rst is low, every register is cleared: addresses, enables, late flags, data, and rf_rd_data_exe. All outputs are 0; hazard_stall is 0.
- **Latencies.**
  - ID→EXE: 1 cycle (address, read data).
  - EXE→MEM: 1 cycle.
  - EXE→WB: D cycles.
  - ID→WB address: D+1 cycles.
- **WB write visibility.** A write at WB in cycle t is invisible to the RF read in cycle t. It is covered by WB forwarding.
- **Same-address writes.** Several in-flight writes to one address with disjoint byte masks merge per byte. Overlapping bytes resolve to the youngest write.
- **Flush during stall.** Enables clear; the remaining state holds.
- **Reset mid-stream.** In-flight writes are lost; no WB write occurs after reset release until new EXE enables arrive.

## Configuration
- **With RISCV_V_RF_FWD_EN defined:**
  - Forwarding as above.
  - hazard_stall is raised only for the late-data case.
- **Without RISCV_V_RF_FWD_EN:**
  - No forwarding muxes; rf_rd_data_exe is rf_rd_data_id registered.
  - hazard_stall is raised when any valid source address equals the EXE address (enables nonzero) or any stage 1..D address (staged enables nonzero), regardless of the late flag.

## Test plan
- **Reset.** Hold rst low for 3 cycles with random inputs → every output is 0. Release, drive rf_wr_en_exe=16'hFFFF, addr 7, data A → rf_wr_en_wb=FFFF, data A, addr 7 after D cycles (addr D+1 from ID).
- **Byte merge.** Writes to v3: WB en 16'h00FF data A; MEM en 16'hFF00 data B. ID reads v3 → rf_rd_data_exe = {B[127:64], A[63:0]}.
- **Priority.** EXE en FFFF data C and MEM en FFFF data B, both to v3 → source gets C. With the EXE late flag set → hazard_stall=1.
- **Late load.** Load to v5 with late data L, a consumer of v5 one instruction later → hazard_stall for 1 cycle. After the external stall, the source gets L forwarded from MEM.
- **Stall and flush.** Stall 2 cycles → all outputs stable. Flush with stall=1 → rf_wr_en_mem and rf_wr_en_wb are 0 the next cycle; addresses unchanged.
- **Build without RISCV_V_RF_FWD_EN.** Valid read of an address in flight at WB → hazard_stall=1; rf_rd_data_exe equals rf_rd_data_id registered.
